scfifo_ctrl: RTL and testbench

SCFIFO_CTRL -- requirements
Module: scfifo_ctrl

---
 rtl/scfifo_pkg.sv | 15 +
 rtl/scfifo_rd_valid_pipe.sv | 26 ++
 rtl/scfifo_ctrl.sv | 102 ++++++++++
 tb/tb_scfifo_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/scfifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
package scfifo_pkg;

    // Address width of the default build; pointers carry one extra wrap bit.
    localparam int SCFIFO_AWIDTH_DEF = 10;

    // Read/write pointer for the default build: AWIDTH address bits plus wrap bit.
    typedef logic [SCFIFO_AWIDTH_DEF:0] scfifo_ptr_t;

    // RAM read latency in cycles as a function of the output-register option.
    function automatic int rd_latency(input int register_output);
        return (register_output != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/scfifo_rd_valid_pipe.sv
// Delay line that turns the RAM read enable into a data-valid strobe
// aligned with the RAM output, STAGES cycles later.
module scfifo_rd_valid_pipe #(
    parameter int STAGES = 1
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic vld_i,
    output logic vld_o
);

    logic [STAGES:1] vld_pipe;

    // Shift the read enable down the pipe; reset drops anything in flight.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= vld_i;
            for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign vld_o = vld_pipe[STAGES];

endmodule

// File: rtl/scfifo_ctrl.sv
// Single-clock FIFO controller driving an external simple dual-port RAM.
// Optional almost_full_o / almost_empty_o flags are compiled in when the
// macro SCFIFO_CTRL_ALMOST_FLAGS_EN is defined.
module scfifo_ctrl
    import scfifo_pkg::*;
#(
    parameter int AWIDTH             = 10,
    parameter int REGISTER_OUTPUT    = 0,
    parameter int ALMOST_FULL_VALUE  = 2**AWIDTH - 4,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [AWIDTH:0]   usedw_o,
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    output logic              almost_full_o,
    output logic              almost_empty_o,
`endif
    output logic [AWIDTH-1:0] ram_wr_addr_o,
    output logic [AWIDTH-1:0] ram_rd_addr_o,
    output logic              ram_wr_en_o,
    output logic              ram_rd_en_o,
    output logic              rd_valid_o
);

    typedef logic [AWIDTH:0] ptr_t;

    localparam int RD_LAT = rd_latency(REGISTER_OUTPUT);

    ptr_t wr_ptr, rd_ptr;
    ptr_t wr_ptr_nxt, rd_ptr_nxt;
    logic wr_acc, rd_acc;

    // Flags come straight from the registered pointers; the wrap bit tells
    // full apart from empty when the address bits match.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                     (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);
    assign usedw_o = wr_ptr - rd_ptr;

    // Reset masks requests so no RAM access leaks out during reset.
    assign wr_acc = wrreq_i && !full_o  && !srst_i;
    assign rd_acc = rdreq_i && !empty_o && !srst_i;

    assign ram_wr_en_o   = wr_acc;
    assign ram_rd_en_o   = rd_acc;
    assign ram_wr_addr_o = wr_ptr[AWIDTH-1:0];
    assign ram_rd_addr_o = rd_ptr[AWIDTH-1:0];

    // Next pointer values: advance by one per accepted operation.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_acc) wr_ptr_nxt = wr_ptr + ptr_t'(1);
        if (rd_acc) rd_ptr_nxt = rd_ptr + ptr_t'(1);
    end

    // Pointer registers; RAM contents are never touched by reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    localparam ptr_t AF_TH = ptr_t'(ALMOST_FULL_VALUE);
    localparam ptr_t AE_TH = ptr_t'(ALMOST_EMPTY_VALUE);

    ptr_t usedw_nxt;
    assign usedw_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // Threshold flags registered from the next fill level so they move in
    // the same cycle as usedw_o.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
        end else begin
            almost_full_o  <= (usedw_nxt >= AF_TH);
            almost_empty_o <= (usedw_nxt <  AE_TH);
        end
    end
`endif

    scfifo_rd_valid_pipe #(
        .STAGES (RD_LAT)
    ) u_rd_valid_pipe (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .vld_i  (rd_acc),
        .vld_o  (rd_valid_o)
    );

endmodule

// File: tb/tb_scfifo_ctrl.sv
// Self-checking bench for scfifo_ctrl (AWIDTH=3, REGISTER_OUTPUT=1).
// A count-based reference model predicts acceptance, flags and addresses;
// each accepted read pushes its expected rd_valid cycle to a scoreboard queue.
module tb_scfifo_ctrl;

    localparam int AW  = 3;
    localparam int DEP = 2**AW;
    localparam int LAT = 2;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b1;
    logic          wrreq_i = 1'b0;
    logic          rdreq_i = 1'b0;
    logic          full_o, empty_o;
    logic [AW:0]   usedw_o;
    logic [AW-1:0] ram_wr_addr_o, ram_rd_addr_o;
    logic          ram_wr_en_o, ram_rd_en_o, rd_valid_o;
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    logic          almost_full_o, almost_empty_o;
`endif

    scfifo_ctrl #(
        .AWIDTH             (AW),
        .REGISTER_OUTPUT    (1),
        .ALMOST_FULL_VALUE  (6),
        .ALMOST_EMPTY_VALUE (2)
    ) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .wrreq_i        (wrreq_i),
        .rdreq_i        (rdreq_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .usedw_o        (usedw_o),
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
`endif
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_rd_en_o    (ram_rd_en_o),
        .rd_valid_o     (rd_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int m_wcnt = 0;   // total accepted writes since reset
    int m_rcnt = 0;   // total accepted reads since reset
    int sb_q[$];      // cycles in which rd_valid_o must be high
    logic [AW:0] msb_seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // One clock: drive requests, check outputs mid-cycle, then update model.
    task automatic step(input logic w, input logic r, input logic rst = 1'b0);
        int  used;
        logic wa, ra, vexp;
        wrreq_i = w; rdreq_i = r; srst_i = rst;
        @(negedge clk_i);
        used = m_wcnt - m_rcnt;
        wa = w && (used != DEP) && !rst;
        ra = r && (used != 0)   && !rst;
        chk("ram_wr_en", 32'(ram_wr_en_o), 32'(wa));
        chk("ram_rd_en", 32'(ram_rd_en_o), 32'(ra));
        chk("usedw",     32'(usedw_o),     32'(used));
        chk("empty",     32'(empty_o),     32'(used == 0));
        chk("full",      32'(full_o),      32'(used == DEP));
        if (wa) chk("wr_addr", 32'(ram_wr_addr_o), 32'(m_wcnt % DEP));
        if (ra) chk("rd_addr", 32'(ram_rd_addr_o), 32'(m_rcnt % DEP));
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
        chk("almost_full",  32'(almost_full_o),  32'(used >= 6));
        chk("almost_empty", 32'(almost_empty_o), 32'(used < 2));
`endif
        vexp = (sb_q.size() > 0) && (sb_q[0] == cyc);
        if (vexp) void'(sb_q.pop_front());
        chk("rd_valid", 32'(rd_valid_o), 32'(vexp));
        if (ra) sb_q.push_back(cyc + LAT);
        @(posedge clk_i);
        cyc++;
        if (rst) begin
            m_wcnt = 0; m_rcnt = 0; sb_q.delete();
        end else begin
            if (wa) m_wcnt++;
            if (ra) m_rcnt++;
        end
        #1;
    endtask

    initial begin
        // Reset, including requests that must be ignored while it is held.
        @(posedge clk_i); #1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);

        // Fill to full, then one rejected write.
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        // Drain all eight; addresses 0..7, valid two cycles later.
        for (int i = 0; i < DEP; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Empty: simultaneous write and read, only the write lands.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Full with simultaneous write and read: read only.
        for (int i = 0; i < DEP - 1; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Bring fill to 4, then 20 cycles of wr+rd: level holds, pointers wrap.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        msb_seen = '0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            msb_seen[dut.rd_ptr[AW]] = 1'b1;
        end
        chk("msb_toggled", 32'(msb_seen[1:0]), 32'h3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset in the middle of a read burst.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
